// File: rtl/adpcm_decoder_mc.sv
// Multi-channel IMA ADPCM decoder with per-channel predictor/step-index register files.
// Optional clip flag and clip-event counter are built when ADPCM_SAT_CNT_EN is defined.
module adpcm_decoder_mc #(
    parameter int unsigned CHANNELS  = 2,
    parameter              STEP_FILE = "dat/step_table.dat"
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [3:0]                             in_code,
    input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] in_chan,
    input  logic                                   hdr_valid,
    input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] hdr_chan,
    input  logic [15:0]                            hdr_sample,
    input  logic [6:0]                             hdr_index,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [15:0]                            out_sample,
    output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] out_chan,
    output logic                                   sat_flag,
    output logic [15:0]                            sat_count
);

    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Step table is built in as a constant ROM so the netlist does not depend on
    // an external init file; STEP_FILE is kept for drop-in parameter compatibility.
    localparam logic [15:0] STEP_TABLE [0:88] = '{
        16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
        16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
        16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
        16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
        16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
        16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
        16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
        16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
        16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
        16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
        16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
        16'd32767
    };

    logic [15:0]        pred_rf [CHANNELS];
    logic [6:0]         idx_rf  [CHANNELS];

    logic               accept;
    logic               in_chan_ok;
    logic               hdr_chan_ok;
    logic [15:0]        cur_pred;
    logic [6:0]         cur_idx;
    logic [15:0]        step;
    logic [16:0]        diff;
    logic signed [17:0] sum;
    logic signed [8:0]  idx_adj;
    logic signed [8:0]  idx_sum;
    logic [15:0]        new_sample;
    logic [6:0]         new_idx;
    logic [6:0]         hdr_idx_clamped;

    assign in_ready    = (!out_valid || out_ready) && !hdr_valid;
    assign accept      = in_valid && in_ready;
    assign in_chan_ok  = 32'(in_chan) < CHANNELS;
    assign hdr_chan_ok = 32'(hdr_chan) < CHANNELS;

    always_comb begin
        cur_pred   = '0;
        cur_idx    = '0;
        if (in_chan_ok) begin
            cur_pred = pred_rf[in_chan];
            cur_idx  = idx_rf[in_chan];
        end
        step = STEP_TABLE[cur_idx];

        diff = 17'(step >> 3);
        if (in_code[2]) diff = diff + 17'(step);
        if (in_code[1]) diff = diff + 17'(step >> 1);
        if (in_code[0]) diff = diff + 17'(step >> 2);

        // 18 bits: predictor +/- the largest diff (61436) can exceed a 17-bit range
        if (in_code[3])
            sum = $signed({{2{cur_pred[15]}}, cur_pred}) - $signed({1'b0, diff});
        else
            sum = $signed({{2{cur_pred[15]}}, cur_pred}) + $signed({1'b0, diff});

        if (sum > 18'sd32767)
            new_sample = 16'h7FFF;
        else if (sum < -18'sd32768)
            new_sample = 16'h8000;
        else
            new_sample = sum[15:0];

        if (in_code[2])
            idx_adj = $signed({6'b0, in_code[1:0], 1'b0}) + 9'sd2;
        else
            idx_adj = -9'sd1;
        idx_sum = $signed({2'b00, cur_idx}) + idx_adj;

        if (idx_sum < 9'sd0)
            new_idx = '0;
        else if (idx_sum > 9'sd88)
            new_idx = 7'd88;
        else
            new_idx = idx_sum[6:0];

        hdr_idx_clamped = (hdr_index > 7'd88) ? 7'd88 : hdr_index;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                pred_rf[ch] <= '0;
                idx_rf[ch]  <= '0;
            end
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_chan   <= '0;
        end else begin
            if (accept) begin
                out_valid <= in_chan_ok;
                if (in_chan_ok) begin
                    pred_rf[in_chan] <= new_sample;
                    idx_rf[in_chan]  <= new_idx;
                    out_sample       <= new_sample;
                    out_chan         <= in_chan;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Header never coincides with an accept because it forces in_ready low
            if (hdr_valid && hdr_chan_ok) begin
                pred_rf[hdr_chan] <= hdr_sample;
                idx_rf[hdr_chan]  <= hdr_idx_clamped;
            end
        end
    end

`ifdef ADPCM_SAT_CNT_EN
    logic        clipped;
    logic        sat_flag_q;
    logic [15:0] sat_count_q;

    assign clipped = (sum > 18'sd32767) || (sum < -18'sd32768);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
        end else if (accept && in_chan_ok) begin
            sat_flag_q <= clipped;
            if (clipped && (sat_count_q != 16'hFFFF))
                sat_count_q <= sat_count_q + 16'd1;
        end
    end

    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;
`else
    assign sat_flag  = 1'b0;
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_adpcm_decoder_mc.sv
// Scoreboard bench for adpcm_decoder_mc: randomized codes/headers/back-pressure against
// an arithmetic reference model; a monitor pops expectations on each output handshake.
module tb_adpcm_decoder_mc;

    localparam int CHANNELS = 2;
    localparam int CH_W     = 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      in_code = '0;
    logic [CH_W-1:0] in_chan = '0;
    logic            hdr_valid = 1'b0;
    logic [CH_W-1:0] hdr_chan = '0;
    logic [15:0]     hdr_sample = '0;
    logic [6:0]      hdr_index = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [15:0]     out_sample;
    logic [CH_W-1:0] out_chan;
    logic            sat_flag;
    logic [15:0]     sat_count;

    adpcm_decoder_mc #(.CHANNELS(CHANNELS)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_chan(in_chan),
        .hdr_valid(hdr_valid), .hdr_chan(hdr_chan), .hdr_sample(hdr_sample), .hdr_index(hdr_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample), .out_chan(out_chan),
        .sat_flag(sat_flag), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sample;
        int chan;
        int flag;
        int count;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    const int STEPS [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
        253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
        1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
        3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487,
        12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    int m_pred [CHANNELS];
    int m_idx  [CHANNELS];
    bit m_ov;
    int m_sat;

    function automatic int to_signed16(input logic [15:0] v);
        return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    endfunction

    task automatic check(input string name, input int actual, input int required);
        vectors++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_pred[c] = 0;
            m_idx[c]  = 0;
        end
        m_ov  = 0;
        m_sat = 0;
        exp_q.delete();
    endtask

    task automatic model_code(input int code, input int ch);
        int   step, diff, s, mag;
        bit   clip;
        exp_t e;
        if (ch >= CHANNELS) return;
        mag  = code % 8;
        step = STEPS[m_idx[ch]];
        diff = step / 8;
        if (mag >= 4)     diff += step;
        if (mag % 4 >= 2) diff += step / 2;
        if (mag % 2 == 1) diff += step / 4;
        s    = (code >= 8) ? m_pred[ch] - diff : m_pred[ch] + diff;
        clip = (s > 32767) || (s < -32768);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        m_pred[ch] = s;
        m_idx[ch] += (mag < 4) ? -1 : (mag - 3) * 2;
        if (m_idx[ch] < 0)  m_idx[ch] = 0;
        if (m_idx[ch] > 88) m_idx[ch] = 88;
`ifdef ADPCM_SAT_CNT_EN
        if (clip && m_sat < 65535) m_sat++;
        e.flag = clip ? 1 : 0;
`else
        e.flag = 0;
`endif
        e.sample = s;
        e.chan   = ch;
        e.count  = m_sat;
        exp_q.push_back(e);
    endtask

    // One cycle: drive after a negedge, check held output and in_ready, predict, wait next negedge.
    task automatic drive(input bit iv, input int code, input int ch, input bit hv, input int hch,
                         input int hs, input int hi, input bit ordy);
        bit acc, rdy_exp;
        in_valid   = iv;
        in_code    = 4'(code);
        in_chan    = CH_W'(ch);
        hdr_valid  = hv;
        hdr_chan   = CH_W'(hch);
        hdr_sample = 16'(hs);
        hdr_index  = 7'(hi);
        out_ready  = ordy;
        #1;
        check("out_valid", int'(out_valid), int'(m_ov));
        if (m_ov && exp_q.size() > 0) begin
            check("held_sample", to_signed16(out_sample), exp_q[0].sample);
            check("held_chan", int'(out_chan), exp_q[0].chan);
        end
        rdy_exp = (!m_ov || ordy) && !hv;
        check("in_ready", int'(in_ready), int'(rdy_exp));
        acc = iv && rdy_exp;
        if (acc) begin
            m_ov = (ch < CHANNELS);
            model_code(code, ch);
        end else if (ordy) begin
            m_ov = 0;
        end
        if (hv && hch < CHANNELS) begin
            m_pred[hch] = to_signed16(16'(hs));
            m_idx[hch]  = (hi > 88) ? 88 : hi;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sample", int'(out_sample), 0);
        check("rst_out_chan", int'(out_chan), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        check("rst_sat_count", int'(sat_count), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every output handshake pops the oldest expectation.
    always @(posedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_output: got sample %0d chan %0d, expected none",
                         to_signed16(out_sample), out_chan);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_sample", to_signed16(out_sample), e.sample);
                check("out_chan", int'(out_chan), e.chan);
                check("sat_flag", int'(sat_flag), e.flag);
                check("sat_count", int'(sat_count), e.count);
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Case 1: first code after reset decodes to 7
        drive(1, 4'h4, 0, 0, 0, 0, 0, 1);
        check("case1_sample", to_signed16(out_sample), 7);
        check("case1_idx", m_idx[0], 2);
        drive(1, 4'hC, 0, 0, 0, 0, 0, 1);
        drive(1, 4'h0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Case 3: header at full scale then positive code saturates; oversize index clamps
        drive(0, 0, 0, 1, 1, 32767, 100, 1);
        drive(1, 4'h7, 1, 0, 0, 0, 0, 1);
        drive(1, 4'h7, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, -32768, 88, 1);
        drive(1, 4'hF, 0, 0, 0, 0, 0, 1);

        // Case 4: interleaved channels, back-to-back
        do_reset();
        drive(1, 4'h4, 0, 0, 0, 0, 0, 1);
        drive(1, 4'hC, 1, 0, 0, 0, 0, 1);
        drive(1, 4'h4, 0, 0, 0, 0, 0, 1);

        // Case 5: back-pressure with a code waiting and a header arriving while held
        drive(1, 4'h5, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 4'h3, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1000, 20, 0);
        drive(1, 4'h3, 0, 0, 0, 0, 0, 1);

        // Case 6: reset while an output is held drops it
        drive(1, 4'h6, 1, 0, 0, 0, 0, 0);
        do_reset();
        drive(1, 4'h4, 0, 0, 0, 0, 0, 1);
        check("case6_sample", to_signed16(out_sample), 7);
        check("case6_chan", int'(out_chan), 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, CHANNELS - 1)),
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, CHANNELS - 1)),
                  int'($urandom_range(0, 65535)), int'($urandom_range(0, 127)),
                  $urandom_range(0, 9) < 7);
        end

        // Drain, bounded
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
